// File: rtl/pool1_ctrl.sv
// Sequencer for the six-lane pool1 datapath: 2x2-window f2 read walk, shared lane clear, f3 write strobe.
// Optional synchronous abort input is enabled by defining POOL1_ABORT_EN.
module pool1_ctrl #(
  parameter int IN_W   = 28,
  parameter int OUT_W  = 14,
  parameter int F2_AW  = 10,
  parameter int F3_AW  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pool1_start,
  output logic             pool1_busy,
  output logic             pool1_done,
  output logic             f2_rd_en,
  output logic [F2_AW-1:0] f2_raddr,
  output logic             pool1_clr,
  output logic             f3_we,
  output logic [F3_AW-1:0] f3_waddr
`ifdef POOL1_ABORT_EN
  ,
  input  logic             pool1_abort
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned PD = RD_LAT + 4;
  localparam int unsigned CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [1:0]       r_state;
  logic [1:0]       r_elem;
  logic [CW-1:0]    r_col;
  logic [CW-1:0]    r_row;
  logic [F2_AW-1:0] r_rowbase;
  logic [PD-1:0]    r_pipe;
  logic [F3_AW-1:0] r_wcnt;
  logic             r_rd_en;
  logic [F2_AW-1:0] r_raddr;
  logic             r_busy;
  logic             r_done;
  logic [F3_AW-1:0] r_waddr;

  logic [1:0]       w_elem_n;
  logic [CW-1:0]    w_col_n;
  logic [CW-1:0]    w_row_n;
  logic [F2_AW-1:0] w_rowbase_n;
  logic [F2_AW-1:0] w_raddr_n;
  logic             w_last;
  logic             w_first;
  logic             w_lastwr;
  logic             w_abort;

`ifdef POOL1_ABORT_EN
  assign w_abort = pool1_abort && (r_state == S_RUN || r_state == S_DRAIN);
`else
  assign w_abort = 1'b0;
`endif

  // Counters describe the element currently on f2_raddr; row base steps by two map rows per window row.
  always_comb begin
    w_elem_n    = r_elem + 2'd1;
    w_col_n     = r_col;
    w_row_n     = r_row;
    w_rowbase_n = r_rowbase;
    if (r_elem == 2'd3) begin
      if (r_col == CW'(OUT_W - 1)) begin
        w_col_n     = '0;
        w_row_n     = r_row + CW'(1);
        w_rowbase_n = r_rowbase + F2_AW'(2 * IN_W);
      end else begin
        w_col_n = r_col + CW'(1);
      end
    end
    w_raddr_n = w_rowbase_n + F2_AW'({w_col_n, w_elem_n[0]})
              + (w_elem_n[1] ? F2_AW'(IN_W) : '0);
  end

  assign w_last   = (r_elem == 2'd3) && (r_col == CW'(OUT_W - 1)) && (r_row == CW'(OUT_W - 1));
  assign w_first  = r_rd_en && (r_elem == 2'd0);
  assign w_lastwr = f3_we && (r_waddr == F3_AW'(OUT_W * OUT_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_elem    <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rowbase <= '0;
      r_pipe    <= '0;
      r_wcnt    <= '0;
      r_rd_en   <= 1'b0;
      r_raddr   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_waddr   <= '0;
    end else begin
      r_pipe <= {r_pipe[PD-2:0], w_first};
      // Write address is presented only during the write cycle, one cycle behind the pipe tap before it.
      if (r_pipe[RD_LAT+2]) begin
        r_waddr <= r_wcnt;
        r_wcnt  <= r_wcnt + F3_AW'(1);
      end else begin
        r_waddr <= '0;
      end
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pool1_start) begin
            r_state   <= S_RUN;
            r_rd_en   <= 1'b1;
            r_raddr   <= '0;
            r_elem    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rowbase <= '0;
            r_wcnt    <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_raddr <= '0;
          end else begin
            r_elem    <= w_elem_n;
            r_col     <= w_col_n;
            r_row     <= w_row_n;
            r_rowbase <= w_rowbase_n;
            r_raddr   <= w_raddr_n;
          end
        end
        S_DRAIN: begin
          if (w_lastwr) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_abort) begin
        r_state <= S_IDLE;
        r_rd_en <= 1'b0;
        r_raddr <= '0;
        r_pipe  <= '0;
        r_waddr <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end
    end
  end

  assign pool1_busy = r_busy;
  assign pool1_done = r_done;
  assign f2_rd_en   = r_rd_en;
  assign f2_raddr   = r_raddr;
  assign pool1_clr  = r_pipe[RD_LAT-1];
  assign f3_we      = r_pipe[RD_LAT+3];
  assign f3_waddr   = r_waddr;

endmodule

// File: tb/tb_pool1_ctrl.sv
// Scoreboard bench for pool1_ctrl with a six-lane ramp-data pool datapath model attached.
module tb_pool1_ctrl;
  localparam int IN_W   = 28;
  localparam int OUT_W  = 14;
  localparam int F2_AW  = 10;
  localparam int F3_AW  = 8;
  localparam int RD_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pool1_start;
  logic             pool1_busy;
  logic             pool1_done;
  logic             f2_rd_en;
  logic [F2_AW-1:0] f2_raddr;
  logic             pool1_clr;
  logic             f3_we;
  logic [F3_AW-1:0] f3_waddr;
`ifdef POOL1_ABORT_EN
  logic             pool1_abort = 1'b0;
`endif

  pool1_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .F2_AW(F2_AW), .F3_AW(F3_AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pool1_start(pool1_start),
    .pool1_busy(pool1_busy), .pool1_done(pool1_done),
    .f2_rd_en(f2_rd_en), .f2_raddr(f2_raddr), .pool1_clr(pool1_clr),
    .f3_we(f3_we), .f3_waddr(f3_waddr)
`ifdef POOL1_ABORT_EN
    , .pool1_abort(pool1_abort)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int val; int aux; } ev_t;
  ev_t rd_q[$];
  ev_t clr_q[$];
  ev_t wr_q[$];
  ev_t done_q[$];

  int checks = 0;
  int errors = 0;
  int c0 = 0;
  int busy_from = 1;
  int busy_to = 0;
  int d[1:6];
  int acc[1:6];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  // Six f2 memories holding f2_n[a] = a + n, and six pool lanes (load on clear, else running max).
  always @(posedge clk) begin
    for (int n = 1; n <= 6; n++) begin
      if (f2_rd_en) d[n] <= int'(f2_raddr) + n;
      if (pool1_clr) acc[n] <= d[n];
      else if (d[n] > acc[n]) acc[n] <= d[n];
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      chk("busy", int'(pool1_busy), int'(cyc >= busy_from && cyc <= busy_to));
      if (f2_rd_en || (rd_q.size() > 0 && rd_q[0].cyc == cyc)) begin
        if (rd_q.size() == 0) chk("rd_extra", cyc, -1);
        else begin
          e = rd_q.pop_front();
          chk("rd_cyc", f2_rd_en ? cyc : -1, e.cyc);
          chk("rd_addr", int'(f2_raddr), e.val);
        end
      end
      if (pool1_clr || (clr_q.size() > 0 && clr_q[0].cyc == cyc)) begin
        if (clr_q.size() == 0) chk("clr_extra", cyc, -1);
        else begin
          e = clr_q.pop_front();
          chk("clr_cyc", pool1_clr ? cyc : -1, e.cyc);
        end
      end
      if (f3_we || (wr_q.size() > 0 && wr_q[0].cyc == cyc)) begin
        if (wr_q.size() == 0) chk("wr_extra", cyc, -1);
        else begin
          e = wr_q.pop_front();
          chk("wr_cyc", f3_we ? cyc : -1, e.cyc);
          chk("wr_addr", int'(f3_waddr), e.val);
          for (int n = 1; n <= 6; n++) chk($sformatf("lane%0d", n), acc[n], e.aux + n);
        end
      end
      if (pool1_done || (done_q.size() > 0 && done_q[0].cyc == cyc)) begin
        if (done_q.size() == 0) chk("done_extra", cyc, -1);
        else begin
          e = done_q.pop_front();
          chk("done_cyc", pool1_done ? cyc : -1, e.cyc);
        end
      end
    end
  end

  task automatic flush();
    rd_q.delete();
    clr_q.delete();
    wr_q.delete();
    done_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, int'(f2_rd_en), 0);
    chk({tag, "_raddr"}, int'(f2_raddr), 0);
    chk({tag, "_clr"},   int'(pool1_clr), 0);
    chk({tag, "_we"},    int'(f3_we), 0);
    chk({tag, "_waddr"}, int'(f3_waddr), 0);
    chk({tag, "_done"},  int'(pool1_done), 0);
    chk({tag, "_busy"},  int'(pool1_busy), 0);
  endtask

  // Start is driven high through cycle c0; reads begin at t0 = c0 + 1.
  task automatic start_frame();
    int r, c, a;
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < OUT_W * OUT_W; k++) begin
      r = k / OUT_W;
      c = k % OUT_W;
      for (int e = 0; e < 4; e++) begin
        a = (2 * r + e / 2) * IN_W + 2 * c + e % 2;
        rd_q.push_back('{c0 + 1 + 4 * k + e, a, 0});
      end
      clr_q.push_back('{c0 + 1 + 4 * k + RD_LAT, 0, 0});
      wr_q.push_back('{c0 + 1 + 4 * k + RD_LAT + 4, k, 29 + 56 * r + 2 * c});
    end
    done_q.push_back('{c0 + 1 + 780 + RD_LAT + 5, 0, 0});
    busy_from = c0 + 1;
    busy_to   = c0 + 1 + 780 + RD_LAT + 5;
    pool1_start = 1'b1;
  endtask

  task automatic run_frame(input int p1, input int p2, input int rst_at, input int ab_at);
    start_frame();
    for (int n = 0; n < 900; n++) begin
      @(negedge clk);
      pool1_start = (cyc == c0 + p1 || cyc == c0 + p2) ? 1'b1 : 1'b0;
      if (rst_at >= 0 && cyc == c0 + rst_at) begin
        #1 rst_n = 1'b0;
        flush();
        busy_to = busy_from - 1;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
`ifdef POOL1_ABORT_EN
      if (ab_at >= 0 && cyc == c0 + ab_at) begin
        #1 pool1_abort = 1'b1;
        flush();
        busy_to = c0 + ab_at;
        @(negedge clk);
        #1 pool1_abort = 1'b0;
      end
`else
      if (ab_at >= 0 && n < 0) break;
`endif
      if (cyc >= c0 + 792) break;
    end
    pool1_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_left", rd_q.size(), 0);
    chk("clr_left", clr_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    flush();
  endtask

  initial begin
    rst_n = 1'b0;
    pool1_start = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1 chk_zero("idle");

    run_frame(-1, -1, -1, -1);
    run_frame(100, 1 + 780 + RD_LAT + 5, -1, -1);
    run_frame(-1, -1, 400, -1);
    #1 chk_zero("postrst");
    run_frame(-1, -1, -1, -1);
`ifdef POOL1_ABORT_EN
    run_frame(-1, -1, -1, 300);
    run_frame(-1, -1, -1, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
